// File: rtl/hyper_ram_responder.sv
// HyperBus device-side responder: decodes the 48-bit command/address, waits out the
// initial latency and serves linear bursts from an internal 16-bit array or CR0.
module hyper_ram_responder #(
    parameter int          MEM_WORDS  = 1024,
    parameter int          LAT_CYCLES = 12,
    parameter int          DOUBLE_LAT = 1,
    parameter logic [15:0] CR0_RESET  = 16'h8F1F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        csn_i,
    input  logic [7:0]  dq_i,
    output logic [7:0]  dq_o,
    output logic        dq_oe_o,
    input  logic        rwds_i,
    output logic        rwds_o,
    output logic        rwds_oe_o,
    output logic [15:0] cr0_o,
    output logic        busy_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          LAT_TOTAL = LAT_CYCLES << DOUBLE_LAT;
    localparam logic [15:0] LAT_LOAD  = 16'(LAT_TOTAL - 1);

    typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA} state_t;

    state_t        state_reg;
    logic [47:0]   ca_reg;
    logic [2:0]    ca_cnt_reg;
    logic [15:0]   lat_cnt_reg;
    logic [AW-1:0] addr_reg;
    logic          is_read_reg;
    logic          is_reg_reg;
    logic          odd_reg;
    logic          cr0_done_reg;
    logic [7:0]    wr_hi_reg;
    logic          wr_hi_en_reg;
    logic [7:0]    dq_reg;
    logic          dq_oe_reg;
    logic          rwds_reg;
    logic          rwds_oe_reg;
    logic          busy_reg;
    logic [15:0]   cr0_reg;

    // The sixth CA byte is decoded straight from dq_i so the access starts on that edge.
    logic [47:0]   ca_word;
    logic [31:0]   ca_addr_full;
    logic [AW-1:0] ca_addr;
    logic          ca_unused;

    assign ca_word      = {ca_reg[39:0], dq_i};
    assign ca_addr_full = {ca_word[44:16], ca_word[2:0]};
    assign ca_addr      = ca_addr_full[AW-1:0];
    assign ca_unused    = ^{ca_reg[47:40], ca_word[45], ca_word[15:3], ca_addr_full};

    logic [AW-1:0] rd_addr;
    logic [1:0]    mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   rdata;
    logic [15:0]   rd_word;

    // The read port runs one word ahead during a burst so the next high byte is ready
    // on the edge that ends the current low byte.
    always_comb begin
        rd_addr = addr_reg;
        if (state_reg == CA)
            rd_addr = ca_addr;
        else if (state_reg == RDATA)
            rd_addr = addr_reg + AW'(1);
    end

    always_comb begin
        mem_we    = 2'b00;
        mem_wdata = {wr_hi_reg, dq_i};
        if (state_reg == WDATA && !is_reg_reg && odd_reg) begin
            if (csn_i)
                mem_we = {wr_hi_en_reg, 1'b0};
            else
                mem_we = {wr_hi_en_reg, ~rwds_i};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];
            logic [7:0] lane_q;

            always_ff @(posedge clk_i) begin
                if (mem_we[gi])
                    lane_mem[addr_reg] <= mem_wdata[gi*8 +: 8];
                lane_q <= lane_mem[rd_addr];
            end

            assign rdata[gi*8 +: 8] = lane_q;
        end
    endgenerate

    assign rd_word = is_reg_reg ? cr0_reg : rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            ca_reg       <= '0;
            ca_cnt_reg   <= '0;
            lat_cnt_reg  <= '0;
            addr_reg     <= '0;
            is_read_reg  <= 1'b0;
            is_reg_reg   <= 1'b0;
            odd_reg      <= 1'b0;
            cr0_done_reg <= 1'b0;
            wr_hi_reg    <= '0;
            wr_hi_en_reg <= 1'b0;
            dq_reg       <= '0;
            dq_oe_reg    <= 1'b0;
            rwds_reg     <= 1'b0;
            rwds_oe_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            cr0_reg      <= CR0_RESET;
        end else if (csn_i) begin
            state_reg   <= IDLE;
            ca_reg      <= '0;
            ca_cnt_reg  <= '0;
            odd_reg     <= 1'b0;
            dq_oe_reg   <= 1'b0;
            rwds_reg    <= 1'b0;
            rwds_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ca_reg      <= {40'd0, dq_i};
                    ca_cnt_reg  <= 3'd1;
                    state_reg   <= CA;
                    busy_reg    <= 1'b1;
                    rwds_oe_reg <= 1'b1;
                    rwds_reg    <= (DOUBLE_LAT != 0);
                end
                CA: begin
                    ca_reg     <= ca_word;
                    ca_cnt_reg <= ca_cnt_reg + 3'd1;
                    if (ca_cnt_reg == 3'd5) begin
                        is_read_reg  <= ca_word[47];
                        is_reg_reg   <= ca_word[46];
                        addr_reg     <= ca_addr;
                        odd_reg      <= 1'b0;
                        cr0_done_reg <= 1'b0;
                        rwds_oe_reg  <= 1'b0;
                        rwds_reg     <= 1'b0;
                        if (!ca_word[47] && ca_word[46]) begin
                            state_reg <= WDATA;
                        end else begin
                            state_reg   <= LAT;
                            lat_cnt_reg <= LAT_LOAD;
                        end
                    end
                end
                LAT: begin
                    if (lat_cnt_reg == 16'd0) begin
                        if (is_read_reg) begin
                            state_reg   <= RDATA;
                            dq_reg      <= rd_word[15:8];
                            dq_oe_reg   <= 1'b1;
                            rwds_reg    <= 1'b1;
                            rwds_oe_reg <= 1'b1;
                            odd_reg     <= 1'b1;
                        end else begin
                            state_reg <= WDATA;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 16'd1;
                    end
                end
                WDATA: begin
                    if (!odd_reg) begin
                        wr_hi_reg    <= dq_i;
                        wr_hi_en_reg <= ~rwds_i;
                        odd_reg      <= 1'b1;
                    end else begin
                        odd_reg  <= 1'b0;
                        addr_reg <= addr_reg + AW'(1);
                        if (is_reg_reg && !cr0_done_reg) begin
                            cr0_done_reg <= 1'b1;
                            if (wr_hi_en_reg)
                                cr0_reg[15:8] <= wr_hi_reg;
                            if (!rwds_i)
                                cr0_reg[7:0] <= dq_i;
                        end
                    end
                end
                RDATA: begin
                    if (odd_reg) begin
                        dq_reg   <= rd_word[7:0];
                        rwds_reg <= 1'b0;
                        odd_reg  <= 1'b0;
                    end else begin
                        dq_reg   <= rd_word[15:8];
                        rwds_reg <= 1'b1;
                        odd_reg  <= 1'b1;
                        addr_reg <= addr_reg + AW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dq_o      = dq_reg;
    assign dq_oe_o   = dq_oe_reg;
    assign rwds_o    = rwds_reg;
    assign rwds_oe_o = rwds_oe_reg;
    assign cr0_o     = cr0_reg;
    assign busy_o    = busy_reg;

endmodule
